// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding the architectural HI/LO
// registers. It sits in the EX stage directly after the register file.
//
// Ports:
//   clk    - clock; all state updates on the rising edge
//   reset  - asynchronous active-high reset; clears all state immediately
//   Start  - request, sampled on a rising edge while Busy is low
//   Op     - 0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=no-op
//   A, B   - rs / rt operands (ReadData1 / ReadData2)
//   Busy   - high while an iterative operation is in flight
//   Done   - one-cycle pulse after HI/LO take an iterative result
//   Hi, Lo - HI and LO registers
//
// Optional feature: define MULDIV_FAST_MULT_EN to make MULT/MULTU complete
// combinationally on the accepting edge. DIV/DIVU stay iterative either way.

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, next_state;

  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] a_raw;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic             done_q;

  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             iter_op;
  logic             accept;
  logic             last_step;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Signed ops iterate on magnitudes; the recorded signs are applied in FIX.
  assign op_signed = (Op == 3'd0) || (Op == 3'd2);
  assign a_neg     = op_signed & A[WIDTH-1];
  assign b_neg     = op_signed & B[WIDTH-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_raw;
  logic [2*WIDTH-1:0] fast_prod;

  // Single-cycle multiplier; only divides go through the iterative datapath.
  assign iter_op   = (Op == 3'd2) || (Op == 3'd3);
  assign fast_raw  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
  assign fast_prod = (a_neg ^ b_neg) ? -fast_raw : fast_raw;
`else
  assign iter_op   = ~Op[2];
`endif

  assign accept    = (state == IDLE) && Start;
  assign last_step = (count == CW'(WIDTH - 1));

  assign Busy = (state != IDLE);
  assign Done = done_q;

  // One iteration step for each algorithm. Multiply keeps {acc_hi, acc_lo}
  // as the partial product with the multiplier shifting out of acc_lo.
  // Divide keeps the partial remainder in acc_hi while the dividend shifts
  // out of the top of acc_lo and quotient bits shift in at the bottom.
  // div_diff carries an extra bit because the shifted remainder can reach
  // 2^WIDTH before the subtract.
  always_comb begin
    mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_reg};
  end

  // Sign correction applied when the result is written back in FIX.
  // For divide the remainder follows the dividend sign (truncating division).
  always_comb begin
    prod_raw = {acc_hi[WIDTH-1:0], acc_lo};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    quo_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix  = neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic: WIDTH steps in RUN, then one FIX cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept && iter_op) next_state = RUN;
      RUN:  if (last_step) next_state = FIX;
      FIX:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and architectural registers. Hi/Lo are only written on accept
  // (MTHI/MTLO, fast multiply) or in FIX, so partial results never leak out.
  // Requests arriving while not IDLE are ignored entirely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      b_reg    <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      done_q   <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (iter_op) begin
              acc_hi   <= '0;
              acc_lo   <= a_mag;
              b_reg    <= b_mag;
              a_raw    <= A;
              is_div   <= Op[1];
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              div_zero <= (B == '0);
              count    <= '0;
            end
`ifdef MULDIV_FAST_MULT_EN
            else if ((Op == 3'd0) || (Op == 3'd1)) begin
              Hi     <= fast_prod[2*WIDTH-1:WIDTH];
              Lo     <= fast_prod[WIDTH-1:0];
              done_q <= 1'b1;
            end
`endif
            else if (Op == 3'd4) begin
              Hi <= A;
            end else if (Op == 3'd5) begin
              Lo <= A;
            end
          end
        end
        RUN: begin
          if (is_div) begin
            if (!div_diff[WIDTH+1]) begin
              acc_hi <= div_diff[WIDTH:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift;
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= {1'b0, mul_sum[WIDTH:1]};
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          count <= count + CW'(1);
        end
        FIX: begin
          // Divide by zero bypasses sign correction: Lo=all ones, Hi=A.
          if (is_div) begin
            if (div_zero) begin
              Hi <= a_raw;
              Lo <= '1;
            end else begin
              Hi <= rem_fix;
              Lo <= quo_fix;
            end
          end else begin
            Hi <= prod_fix[2*WIDTH-1:WIDTH];
            Lo <= prod_fix[WIDTH-1:0];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Expected HI/LO pairs
// are queued when an operation is issued and popped when Done pulses.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_muldiv_unit;

  localparam int WIDTH = 32;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = WIDTH + 2;
  localparam int MUL_BUSY = WIDTH + 1;
`endif
  localparam int DIV_LAT  = WIDTH + 2;
  localparam int DIV_BUSY = WIDTH + 1;

  logic             clk;
  logic             reset;
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sbQueue[$];

  int totalChecks;
  int passChecks;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .Start(Start),
    .Op   (Op),
    .A    (A),
    .B    (B),
    .Busy (Busy),
    .Done (Done),
    .Hi   (Hi),
    .Lo   (Lo)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts a comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    totalChecks++;
    if (actual === expected) begin
      passChecks++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model for the four arithmetic ops, returns {hi, lo}.
  function automatic logic [63:0] refModel(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] res;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (op)
      3'd0: res = 64'(sa * sb);
      3'd1: res = 64'(ua * ub);
      3'd2: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
          res = {r, q};
        end
      end
      3'd3: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q = 32'(ua / ub);
          r = 32'(ua % ub);
          res = {r, q};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Issues one arithmetic op (called on a falling edge), waits for Done with
  // a bound, then pops the scoreboard and compares. Optionally fires an MTLO
  // while the op is busy; that request must be ignored.
  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expHi, input logic [31:0] expLo,
                               input bit injectMtlo);
    int cycles;
    int busyCycles;
    int expLat;
    int expBusy;
    bit held;
    logic [31:0] hi0, lo0;
    exp_t e;
    sbQueue.push_back('{tag, expHi, expLo});
    expLat  = (op[1]) ? DIV_LAT : MUL_LAT;
    expBusy = (op[1]) ? DIV_BUSY : MUL_BUSY;
    hi0 = Hi;
    lo0 = Lo;
    held = 1'b1;
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    @(negedge clk);
    Start = 1'b0;
    Op = 3'd7;
    cycles = 1;
    busyCycles = 0;
    while (!Done && cycles < 100) begin
      if (Busy) busyCycles++;
      if (Hi !== hi0 || Lo !== lo0) held = 1'b0;
      if (injectMtlo) begin
        if (cycles == 3) begin
          Start = 1'b1;
          Op = 3'd5;
          A = 32'hDEAD_BEEF;
        end else if (cycles == 4) begin
          Start = 1'b0;
          Op = 3'd7;
        end
      end
      @(negedge clk);
      cycles++;
    end
    e = sbQueue.pop_front();
    if (!Done) begin
      checkOutput({e.tag, "_timeout"}, 64'(cycles), 64'(expLat));
    end else begin
      checkOutput({e.tag, "_hi"}, {32'd0, Hi}, {32'd0, e.hi});
      checkOutput({e.tag, "_lo"}, {32'd0, Lo}, {32'd0, e.lo});
      checkOutput({e.tag, "_latency"}, 64'(cycles), 64'(expLat));
      checkOutput({e.tag, "_busy"}, 64'(busyCycles), 64'(expBusy));
      if (expLat > 1) checkOutput({e.tag, "_hold"}, {63'd0, held}, 64'd1);
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] rexp;
    totalChecks = 0;
    passChecks = 0;
    reset = 1'b1;
    Start = 1'b0;
    Op = 3'd7;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", {Busy, Done, Hi, Lo}, 66'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases.
    applyStimulus("mult",      3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    applyStimulus("multu",     3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
    applyStimulus("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    applyStimulus("divu",      3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    applyStimulus("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    applyStimulus("divu_zero", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("div_zero",  3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);

    // The Done pulse lasts exactly one cycle.
    @(negedge clk);
    checkOutput("done_pulse", {63'd0, Done}, 64'd0);

    // MTHI / MTLO write on the accepting edge, no Busy or Done.
    Start = 1'b1;
    Op = 3'd4;
    A = 32'h1234_5678;
    @(posedge clk);
    #1;
    checkOutput("mthi", {Busy, Done, Hi}, {2'b00, 32'h1234_5678});
    @(negedge clk);
    Op = 3'd5;
    A = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    checkOutput("mtlo", {Busy, Done, Lo}, {2'b00, 32'h9ABC_DEF0});
    @(negedge clk);

    // Op 6 with Start changes nothing.
    Op = 3'd6;
    A = 32'h5555_AAAA;
    @(negedge clk);
    Start = 1'b0;
    Op = 3'd7;
    checkOutput("op6_noop", {Busy, Done, Hi, Lo}, {2'b00, 32'h1234_5678, 32'h9ABC_DEF0});

    // MTLO issued mid-divide is ignored; Lo changes only with the result.
    applyStimulus("divu_mtlo", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);

    // Back-to-back: start issued in the Done cycle is accepted.
    applyStimulus("b2b_div", 3'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);

    // Random ops checked against the reference model.
    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : $urandom;
      if (i == 2) rb = 32'(rb % 19) + 32'd1;
      rexp = refModel(rop, ra, rb);
      applyStimulus($sformatf("rand%0d", i), rop, ra, rb, rexp[63:32], rexp[31:0], 1'b0);
    end

    // Reset mid-divide clears everything immediately.
    Start = 1'b1;
    Op = 3'd3;
    A = 32'd100;
    B = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    Op = 3'd7;
    repeat (9) @(negedge clk);
    checkOutput("busy_before_reset", {63'd0, Busy}, 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("async_reset", {Busy, Done, Hi, Lo}, 66'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus("post_reset_multu", 3'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

    checkOutput("sb_empty", 64'(sbQueue.size()), 64'd0);
    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers; sits directly downstream of the register file in the EX stage.
- Consumes ReadData1/ReadData2 as operands A/B.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles, and MTHI/MTLO in one cycle.
- Exposes HI/LO for MFHI/MFLO; the hazard logic stalls on Busy.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- Start  input  1  request; sampled at posedge when Busy=0
- Op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7=no-op
- A  input  WIDTH  rs operand (ReadData1)
- B  input  WIDTH  rt operand (ReadData2)
- Busy  output  1  high while an iterative op is in flight
- Done  output  1  one-cycle pulse when HI/LO take an iterative result
- Hi  output  WIDTH  HI register
- Lo  output  WIDTH  LO register

Behaviour:
- Reset: Hi=0, Lo=0, Busy=0, Done=0, FSM=IDLE; all internal accumulators cleared. Applies at any time, including mid-operation; the in-flight op is discarded.
- FSM states: IDLE, RUN, FIX.
- IDLE, Start=1, Op 0-3 (edge 0):
  - capture operands: magnitudes for signed ops, raw values for unsigned ops
  - record result signs; count=0
  - go to RUN; Busy=1
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge, edges 1..WIDTH; then go to FIX.
- FIX (edge WIDTH+1):
  - apply sign correction and write Hi/Lo
  - Busy=0; Done=1 for exactly the following cycle; go to IDLE
- Latency: Hi/Lo valid after edge WIDTH+1 (33 for the default width).
- Hi/Lo stay unchanged during RUN; intermediate results are never visible.
- Multiply results: {Hi,Lo} = full 2*WIDTH product. Signed product is negated when exactly one operand is negative.
- Divide results: Lo=quotient, Hi=remainder.
  - Signed: quotient negated when operand signs differ; remainder takes the dividend's sign (truncating division).
  - -2^31 / -1 yields Lo=0x80000000, Hi=0.
- Divide by zero (B=0, signed or unsigned): Lo=all ones, Hi=A (original A). Still takes full latency; no sign correction.
- MTHI/MTLO in IDLE with Start=1: Hi (resp. Lo) <= A at the same edge; no Busy, no Done.
- Start while Busy=1: ignored entirely, including MTHI/MTLO. Upstream must stall.
- Start in the cycle Done=1: accepted (Busy is already low); Done still deasserts the next cycle unless the new op completes.
- Op 6-7 with Start: no state change.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined: MULT/MULTU complete combinationally. {Hi,Lo} is written at edge 0 (the accepting edge); Busy never asserts; Done pulses the cycle after edge 0. DIV/DIVU are unchanged.
- Undefined: all four ops are iterative as above.

Test Plan:
- MULT A=0xFFFFFFFE, B=3 -> after 33 edges Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; Busy high 33 cycles; Done single pulse. With MULDIV_FAST_MULT_EN: same values after 1 edge, Busy never high.
- MULTU A=0xFFFFFFFE, B=3 -> Hi=0x00000002, Lo=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=100, B=7 -> Lo=0x0000000E, Hi=0x00000002. DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=5, B=0 -> Lo=0xFFFFFFFF, Hi=5. DIV A=0xFFFFFFFB, B=0 -> Lo=0xFFFFFFFF, Hi=0xFFFFFFFB.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 -> Hi/Lo update on the same edge as each Start; Done stays 0. Issue MTLO while a DIV is Busy -> Lo unchanged until the DIV result lands.
- Start DIVU 100/7, assert reset at cycle 10 -> Hi=Lo=0 and Busy=Done=0 immediately. After reset release, MULTU 2*3 completes normally with Hi=0, Lo=6.
